serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
- Consumes the serial bit stream from the d_ff stage (its q output) and assembles WIDTH-bit words.
- Presents each word on a valid/ready output port to the next stage.
- One shift register plus one output holding register, so the next frame can be collected while a word waits for the consumer.

Parameters:
- WIDTH, 8, data bits per frame (2..32).
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  1  serial data bit (driven from d_ff q).
- d_valid  input  1  d is sampled this cycle.
- start  input  1  marks the first bit of a frame; only meaningful with d_valid.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- busy  output  1  frame collection in progress.
- bit_cnt  output  $clog2(WIDTH+1)  bits collected in the current frame.
- overflow  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (async, rst=1): dout=0, dout_valid=0, busy=0, bit_cnt=0, overflow=0, state=IDLE, shift register=0. Deassertion is sampled on the next clk edge.
- FSM states: IDLE, SHIFT (plus PARITY when PARITY_EN is defined).
- IDLE:
  - d_valid & start -> SHIFT; bit stored; bit_cnt=1.
  - d_valid without start is ignored.
- SHIFT:
  - Each d_valid shifts d in and increments bit_cnt.
  - d_valid=0 holds state (gaps allowed).
  - On the WIDTH-th bit, the word completes: go to IDLE (or PARITY) and clear bit_cnt to 0.
- start asserted in SHIFT with d_valid: abort the partial frame and restart with this bit as bit 1. No word is output and overflow is not set.
- Word transfer:
  - dout and dout_valid update the cycle after the last bit is sampled (latency 1 clk from the final d_valid).
  - dout_valid stays high until the cycle dout_valid & dout_ready; it drops the next cycle unless a new word loads in that same cycle.
- Completion while the output register is full (dout_valid=1, dout_ready=0 that cycle): drop the new word, keep the old dout, set overflow=1.
- Completion in the same cycle as dout_ready=1: the new word replaces the old one and dout_valid stays 1 (no bubble).
- overflow is cleared only by rst.
- busy=1 exactly when state != IDLE.
- rst asserted mid-frame discards the partial frame and any held word immediately.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Defined:
  - After WIDTH data bits the FSM enters PARITY and the next d_valid bit is even parity over the word.
  - Extra output parity_err (1 bit, reset 0). It updates together with dout_valid: 1 if the XOR of the word and the parity bit is 1.
  - start during PARITY aborts like SHIFT.
  - The overflow rules apply at parity-bit completion.
- Undefined: no PARITY state, no parity_err port; the word completes on the WIDTH-th bit.

Decomposition:
- Package serial_deser_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - constant DESER_MAX_WIDTH=32;
  - a function computing the bit_cnt width.
- One sub-module, deser_out_reg: output holding register with valid/ready, load, and overflow-detect logic, parameterised by WIDTH.

Test Plan (WIDTH=8 unless stated):
- MSB_FIRST=1; bits 1,0,1,1,0,0,1,0 with start on the first bit, dout_ready=1 -> dout=8'hB2, dout_valid one cycle after the 8th bit, overflow=0.
- MSB_FIRST=0; same bits -> dout=8'h4D.
- dout_ready=0; send 8'hB2 then a full frame 8'h0F -> dout stays 8'hB2, overflow=1. Later dout_ready=1 -> dout_valid drops; overflow stays 1.
- Send 4 bits, then start with bits 1,1,1,1,1,1,1,1 -> single word 8'hFF, no extra dout_valid, overflow=0.
- rst pulse after 5 bits of a frame with a held word -> all outputs 0 immediately. The next full frame 8'hA5 outputs correctly.
- SERIAL_DESER_PARITY_EN: frame 8'hB2 plus parity 0 -> parity_err=0. Parity 1 -> parity_err=1, dout=8'hB2.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// Shared types and helpers for the serial deserializer.
// The PARITY state is only reachable when SERIAL_DESER_PARITY_EN is defined.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_e;

  localparam int DESER_MAX_WIDTH = 32;

  // Counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int bit_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Output holding register with valid/ready handshake; a load that arrives
// while a word is still held and not being consumed is dropped and flagged.
module deser_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // A consume and a load in the same cycle replace the word with no bubble.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      if (!valid_q || ready_i) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with valid/ready output and sticky overflow.
// Define SERIAL_DESER_PARITY_EN to expect an even-parity bit after each word.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               d,
  input  logic                               d_valid,
  input  logic                               start,
  output logic [WIDTH-1:0]                   dout,
  output logic                               dout_valid,
  input  logic                               dout_ready,
  output logic                               busy,
  output logic [bit_cnt_width(WIDTH)-1:0]    bit_cnt,
  output logic                               overflow
`ifdef SERIAL_DESER_PARITY_EN
  ,
  output logic                               parity_err
`endif
);

  localparam int             CW       = bit_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > DESER_MAX_WIDTH) begin : g_bad_width
    $error("serial_deserializer: WIDTH out of range");
  end

  deser_state_e     state_q, state_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [WIDTH-1:0] shifted;
  logic             loadWord;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shiftReg_q <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shiftReg_q <= shiftReg_d;
    end
  end

  // Stale bits left from an aborted frame are pushed out by the next WIDTH shifts.
  assign shifted = MSB_FIRST ? {shiftReg_q[WIDTH-2:0], d} : {d, shiftReg_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shiftReg_d = shiftReg_q;
    loadWord   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_valid && start) begin
          state_d    = SHIFT;
          bitCnt_d   = CW'(1);
          shiftReg_d = shifted;
        end
      end
      SHIFT: begin
        if (d_valid) begin
          shiftReg_d = shifted;
          if (start) begin
            bitCnt_d = CW'(1);
          end else if (bitCnt_q == LAST_CNT) begin
            bitCnt_d = '0;
`ifdef SERIAL_DESER_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = IDLE;
            loadWord = 1'b1;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (d_valid) begin
          if (start) begin
            state_d    = SHIFT;
            bitCnt_d   = CW'(1);
            shiftReg_d = shifted;
          end else begin
            state_d  = IDLE;
            loadWord = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        bitCnt_d = '0;
      end
    endcase
  end

`ifdef SERIAL_DESER_PARITY_EN
  // Parity error travels with the word so it updates together with dout_valid.
  logic [WIDTH:0] outData;

  deser_out_reg #(.WIDTH(WIDTH + 1)) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (loadWord),
    .data_i     ({(^shiftReg_q) ^ d, shiftReg_q}),
    .ready_i    (dout_ready),
    .data_o     (outData),
    .valid_o    (dout_valid),
    .overflow_o (overflow)
  );

  assign dout       = outData[WIDTH-1:0];
  assign parity_err = outData[WIDTH];
`else
  deser_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (loadWord),
    .data_i     (shifted),
    .ready_i    (dout_ready),
    .data_o     (dout),
    .valid_o    (dout_valid),
    .overflow_o (overflow)
  );
`endif

  assign busy    = (state_q != IDLE);
  assign bit_cnt = bitCnt_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances share one stimulus
// stream; expected words are queued as frames are sent and popped on handshake.
module tb_serial_deserializer;

`ifdef SERIAL_DESER_PARITY_EN
  localparam bit ParityOn = 1'b1;
`else
  localparam bit ParityOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       d, d_valid, start, dout_ready;
  logic [7:0] doutMsb, doutLsb;
  logic       validMsb, validLsb, busyMsb, busyLsb, ovfMsb, ovfLsb;
  logic [3:0] cntMsb, cntLsb;
`ifdef SERIAL_DESER_PARITY_EN
  logic       perrMsb, perrLsb;
`endif

  int passCount  = 0;
  int totalCount = 0;

  typedef struct {
    logic [7:0] bits;
    logic       parityBit;
    logic [7:0] expMsb;
    logic [7:0] expLsb;
    logic       expPerr;
  } vec_t;

  typedef struct {
    logic [7:0] msb;
    logic [7:0] lsb;
    logic       perr;
  } exp_t;

  exp_t expQ[$];

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .start(start),
    .dout(doutMsb), .dout_valid(validMsb), .dout_ready(dout_ready),
    .busy(busyMsb), .bit_cnt(cntMsb), .overflow(ovfMsb)
`ifdef SERIAL_DESER_PARITY_EN
    , .parity_err(perrMsb)
`endif
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .start(start),
    .dout(doutLsb), .dout_valid(validLsb), .dout_ready(dout_ready),
    .busy(busyLsb), .bit_cnt(cntLsb), .overflow(ovfLsb)
`ifdef SERIAL_DESER_PARITY_EN
    , .parity_err(perrLsb)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard: every handshake must match the oldest queued word.
  always @(negedge clk) begin
    if (!rst && validMsb && dout_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected word", {24'd0, doutMsb}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("dout msb-first", {24'd0, doutMsb}, {24'd0, e.msb});
        checkOutput("dout lsb-first", {24'd0, doutLsb}, {24'd0, e.lsb});
        checkOutput("lsb valid", {31'd0, validLsb}, 32'd1);
`ifdef SERIAL_DESER_PARITY_EN
        checkOutput("parity_err msb", {31'd0, perrMsb}, {31'd0, e.perr});
        checkOutput("parity_err lsb", {31'd0, perrLsb}, {31'd0, e.perr});
`endif
      end
    end
  end

  task automatic sendBit(input logic b, input logic s);
    @(posedge clk); #1;
    d = b; d_valid = 1'b1; start = s;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      d_valid = 1'b0; start = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit push, input bit readyOnLast);
    if (push) expQ.push_back('{msb: v.expMsb, lsb: v.expLsb, perr: v.expPerr});
    for (int i = 7; i >= 0; i--) begin
      sendBit(v.bits[i], i == 7);
      if (readyOnLast && i == 0 && !ParityOn) dout_ready = 1'b1;
    end
    if (ParityOn) begin
      sendBit(v.parityBit, 1'b0);
      if (readyOnLast) dout_ready = 1'b1;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard drained", expQ.size(), 0);
  endtask

  vec_t table_v[8];

  initial begin
    table_v[0] = '{8'hB2, 1'b0, 8'hB2, 8'h4D, 1'b0};
    table_v[1] = '{8'hB2, 1'b1, 8'hB2, 8'h4D, 1'b1};
    table_v[2] = '{8'h0F, 1'b0, 8'h0F, 8'hF0, 1'b0};
    table_v[3] = '{8'hA5, 1'b1, 8'hA5, 8'hA5, 1'b1};
    table_v[4] = '{8'h01, 1'b1, 8'h01, 8'h80, 1'b0};
    table_v[5] = '{8'h80, 1'b0, 8'h80, 8'h01, 1'b1};
    table_v[6] = '{8'h3C, 1'b0, 8'h3C, 8'h3C, 1'b0};
    table_v[7] = '{8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0};

    rst = 1'b1; d = 1'b0; d_valid = 1'b0; start = 1'b0; dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset dout", {24'd0, doutMsb}, 32'd0);
    checkOutput("reset dout_valid", {31'd0, validMsb}, 32'd0);
    checkOutput("reset busy", {31'd0, busyMsb}, 32'd0);
    checkOutput("reset bit_cnt", {28'd0, cntMsb}, 32'd0);
    checkOutput("reset overflow", {31'd0, ovfMsb}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // First frame by hand to pin down the one-cycle output latency.
    applyStimulus(table_v[0], 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("valid before last edge", {31'd0, validMsb}, 32'd0);
    checkOutput("busy on last bit", {31'd0, busyMsb}, 32'd1);
    idleCycles(1);
    @(negedge clk);
    checkOutput("valid after last edge", {31'd0, validMsb}, 32'd1);
    checkOutput("busy after frame", {31'd0, busyMsb}, 32'd0);
    checkOutput("bit_cnt after frame", {28'd0, cntMsb}, 32'd0);
    checkOutput("overflow after frame", {31'd0, ovfMsb}, 32'd0);
    idleCycles(2);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(table_v[i], 1'b1, 1'b0);
      idleCycles(1 + (i % 2));
    end
    waitDrain();
    checkOutput("overflow after table", {31'd0, ovfMsb}, 32'd0);

    // Abort: four bits, then a restart carrying 8'hFF.
    sendBit(1'b1, 1'b1); sendBit(1'b0, 1'b0); sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bit_cnt mid-frame", {28'd0, cntMsb}, 32'd3);
    checkOutput("busy mid-frame", {31'd0, busyMsb}, 32'd1);
    applyStimulus(table_v[7], 1'b1, 1'b0);
    idleCycles(3);
    waitDrain();
    checkOutput("overflow after abort", {31'd0, ovfMsb}, 32'd0);

    // Completion in the same cycle as the consumer accepts: no bubble.
    @(posedge clk); #1 dout_ready = 1'b0;
    applyStimulus(table_v[2], 1'b1, 1'b0);
    idleCycles(2);
    applyStimulus(table_v[3], 1'b1, 1'b1);
    idleCycles(3);
    waitDrain();
    checkOutput("overflow after replace", {31'd0, ovfMsb}, 32'd0);

    // Overflow: a held word blocks a newly completed one.
    @(posedge clk); #1 dout_ready = 1'b0;
    applyStimulus(table_v[0], 1'b1, 1'b0);
    idleCycles(2);
    applyStimulus(table_v[2], 1'b0, 1'b0);
    idleCycles(2);
    @(negedge clk);
    checkOutput("held dout", {24'd0, doutMsb}, 32'hB2);
    checkOutput("held valid", {31'd0, validMsb}, 32'd1);
    checkOutput("overflow set msb", {31'd0, ovfMsb}, 32'd1);
    checkOutput("overflow set lsb", {31'd0, ovfLsb}, 32'd1);
    @(posedge clk); #1 dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("valid drops", {31'd0, validMsb}, 32'd0);
    checkOutput("overflow sticky", {31'd0, ovfMsb}, 32'd1);
    waitDrain();

    // Reset mid-frame with a word held.
    @(posedge clk); #1 dout_ready = 1'b0;
    applyStimulus(table_v[6], 1'b0, 1'b0);
    idleCycles(2);
    @(negedge clk);
    checkOutput("held before rst", {24'd0, doutMsb}, 32'h3C);
    for (int i = 0; i < 5; i++) sendBit(1'b1, i == 0);
    @(posedge clk); #1 rst = 1'b1; d_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("rst dout", {24'd0, doutMsb}, 32'd0);
    checkOutput("rst valid", {31'd0, validMsb}, 32'd0);
    checkOutput("rst busy", {31'd0, busyMsb}, 32'd0);
    checkOutput("rst bit_cnt", {28'd0, cntMsb}, 32'd0);
    checkOutput("rst overflow", {31'd0, ovfMsb}, 32'd0);
    checkOutput("rst dout lsb", {24'd0, doutLsb}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; dout_ready = 1'b1;
    applyStimulus(table_v[3], 1'b1, 1'b0);
    idleCycles(3);
    waitDrain();
    checkOutput("overflow after rst frame", {31'd0, ovfMsb}, 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
